hamming_scrub_ctrl: RTL and testbench

//   Memory scrubber controller for a Hamming(7,4)-protected word store. On start it sweeps

---
 rtl/hamming_scrub_ctrl_if.sv | 30 +++
 rtl/hamming_scrub_ctrl.sv | 153 +++++++++++++++
 tb/tb_hamming_scrub_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_scrub_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : hamming_scrub_ctrl_if
// Brief  : Single-port codeword RAM bus between the scrubber (master) and memory.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hamming_scrub_ctrl_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic              mem_rd_valid;
   logic [6:0]        mem_rd_data;
   logic              mem_wr_en;
   logic              mem_wr_ready;
   logic [6:0]        mem_wr_data;

   modport master (
      output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
      input  mem_rd_valid, mem_rd_data, mem_wr_ready
   );

   modport slave (
      input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
      output mem_rd_valid, mem_rd_data, mem_wr_ready
   );
endinterface

`default_nettype wire

// File: rtl/hamming_scrub_ctrl.sv
//------------------------------------------------------------------------------
// Module : hamming_scrub_ctrl
// Brief  : Hamming(7,4) memory scrubber; sweeps 0..DEPTH-1 and rewrites
//          corrected codewords. Optional macro HAMMING_SCRUB_LOG_EN adds
//          last-error address/syndrome outputs.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hamming_scrub_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 8
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              start,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       err_count,
`ifdef HAMMING_SCRUB_LOG_EN
   output logic [ADDR_W-1:0]      last_err_addr,
   output logic [2:0]             last_err_syn,
`endif
   hamming_scrub_ctrl_if.master   mem
);

   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_CHK  = 3'd3,
      ST_WR   = 3'd4,
      ST_NEXT = 3'd5,
      ST_DONE = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [6:0]        r_rd_word;
   logic [6:0]        r_wr_data;
   logic [CNT_W-1:0]  r_err_count;
   logic [2:0]        w_syn;
   logic [6:0]        w_flip;
   logic [6:0]        w_fixed;

   // Syndrome value is the 1-based position of the bit to flip.
   assign w_syn   = {r_rd_word[3] ^ r_rd_word[4] ^ r_rd_word[5] ^ r_rd_word[6],
                     r_rd_word[1] ^ r_rd_word[2] ^ r_rd_word[5] ^ r_rd_word[6],
                     r_rd_word[0] ^ r_rd_word[2] ^ r_rd_word[4] ^ r_rd_word[6]};
   assign w_flip  = (w_syn == 3'd0) ? 7'd0 : (7'd1 << (w_syn - 3'd1));
   assign w_fixed = r_rd_word ^ w_flip;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_rd_word   <= '0;
         r_wr_data   <= '0;
         r_err_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_addr      <= '0;
                  r_err_count <= '0;
               end
            end
            ST_WAIT: begin
               if (mem.mem_rd_valid) begin
                  r_rd_word <= mem.mem_rd_data;
               end
            end
            ST_CHK: begin
               r_wr_data <= w_fixed;
               if ((w_syn != 3'd0) && (r_err_count != c_cnt_max)) begin
                  r_err_count <= r_err_count + 1'b1;
               end
            end
            ST_NEXT: begin
               if (r_addr != c_last_addr) begin
                  r_addr <= r_addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HAMMING_SCRUB_LOG_EN
   // Deliberately survives start so the last fault stays visible across sweeps.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_err_addr <= '0;
         last_err_syn  <= '0;
      end else if ((r_state == ST_CHK) && (w_syn != 3'd0)) begin
         last_err_addr <= r_addr;
         last_err_syn  <= w_syn;
      end
   end
`endif

   always_comb begin
      w_state_nxt   = r_state;
      busy          = 1'b1;
      done          = 1'b0;
      mem.mem_rd_en = 1'b0;
      mem.mem_wr_en = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = ST_RD;
         end
         ST_RD: begin
            mem.mem_rd_en = 1'b1;
            w_state_nxt   = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem.mem_rd_valid) w_state_nxt = ST_CHK;
         end
         ST_CHK: begin
            w_state_nxt = (w_syn == 3'd0) ? ST_NEXT : ST_WR;
         end
         ST_WR: begin
            mem.mem_wr_en = 1'b1;
            if (mem.mem_wr_ready) w_state_nxt = ST_NEXT;
         end
         ST_NEXT: begin
            w_state_nxt = (r_addr == c_last_addr) ? ST_DONE : ST_RD;
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            busy        = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign mem.mem_addr    = r_addr;
   assign mem.mem_wr_data = r_wr_data;
   assign err_count       = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_hamming_scrub_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_hamming_scrub_ctrl
// Brief  : Self-checking bench for hamming_scrub_ctrl with a reactive memory model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hamming_scrub_ctrl;

   localparam int ADDR_W  = 4;
   localparam int DEPTH   = 16;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [6:0] CLEAN = 7'b1010101;

   logic clk = 1'b1;
   logic rst;
   logic start;
   logic busy;
   logic done;
   logic [CNT_W-1:0] err_count;
`ifdef HAMMING_SCRUB_LOG_EN
   logic [ADDR_W-1:0] last_err_addr;
   logic [2:0]        last_err_syn;
`endif

   hamming_scrub_ctrl_if #(.ADDR_W(ADDR_W)) mem_if ();

   hamming_scrub_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .err_count     (err_count),
`ifdef HAMMING_SCRUB_LOG_EN
      .last_err_addr (last_err_addr),
      .last_err_syn  (last_err_syn),
`endif
      .mem           (mem_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: syndrome is the XOR of the 1-based positions of all set bits.
   function automatic int ref_syn(input logic [6:0] w);
      int s = 0;
      for (int i = 0; i < 7; i++) if (w[i]) s = s ^ (i + 1);
      return s;
   endfunction

   function automatic logic [6:0] ref_fix(input logic [6:0] w);
      logic [6:0] f = w;
      int s = ref_syn(w);
      if (s != 0) f[s-1] = ~f[s-1];
      return f;
   endfunction

   // Memory model: configurable read latency / write back-pressure, optional noise.
   typedef struct { int addr; logic [6:0] data; } wr_t;
   logic [6:0]        mem [DEPTH];
   int                rd_lat_min = 1, rd_lat_max = 1;
   int                wr_dly_min = 0, wr_dly_max = 0;
   bit                noise = 1'b0;
   int                rd_pend = 0;
   int                wr_left = -1;
   int                wr_cycles = 0;
   int                last_wr_cycles = 0;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] wr_addr0;
   logic [6:0]        wr_data0;
   int                rd_log[$];
   wr_t               wr_log[$];

   always @(negedge clk) begin
      if (mem_if.mem_rd_en === 1'b1) begin
         rd_log.push_back(int'(mem_if.mem_addr));
         rd_addr_q           = mem_if.mem_addr;
         rd_pend             = $urandom_range(rd_lat_max, rd_lat_min);
         mem_if.mem_rd_valid = 1'b0;
         mem_if.mem_rd_data  = 7'($urandom);
      end else if (rd_pend > 0) begin
         rd_pend--;
         mem_if.mem_rd_valid = (rd_pend == 0);
         mem_if.mem_rd_data  = (rd_pend == 0) ? mem[rd_addr_q] : 7'($urandom);
      end else begin
         mem_if.mem_rd_valid = noise ? 1'($urandom_range(1, 0)) : 1'b0;
         mem_if.mem_rd_data  = 7'($urandom);
      end

      if (mem_if.mem_wr_en === 1'b1) begin
         if (wr_left < 0) begin
            wr_left   = $urandom_range(wr_dly_max, wr_dly_min);
            wr_cycles = 0;
            wr_addr0  = mem_if.mem_addr;
            wr_data0  = mem_if.mem_wr_data;
         end else begin
            check("wr_addr_stable", 32'(mem_if.mem_addr), 32'(wr_addr0));
            check("wr_data_stable", 32'(mem_if.mem_wr_data), 32'(wr_data0));
         end
         wr_cycles++;
         if (wr_left == 0) begin
            mem_if.mem_wr_ready = 1'b1;
            mem[mem_if.mem_addr] = mem_if.mem_wr_data;
            wr_log.push_back('{addr: int'(mem_if.mem_addr), data: mem_if.mem_wr_data});
            last_wr_cycles = wr_cycles;
            wr_left = -1;
         end else begin
            mem_if.mem_wr_ready = 1'b0;
            wr_left--;
         end
      end else begin
         wr_left             = -1;
         mem_if.mem_wr_ready = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      end
   end

   int exp_last_addr = 0;
   int exp_last_syn  = 0;

   task automatic fill_clean();
      for (int a = 0; a < DEPTH; a++) mem[a] = CLEAN;
   endtask

   task automatic set_lat(input int rlo, input int rhi, input int wlo, input int whi, input bit nz);
      rd_lat_min = rlo; rd_lat_max = rhi; wr_dly_min = wlo; wr_dly_max = whi; noise = nz;
   endtask

   // One full sweep from IDLE, compared against the reference model.
   task automatic run_sweep(input string tag, input bit chk_time, input bit poke_start);
      wr_t exp_q[$];
      int  nerr = 0;
      int  cyc;
      int  bad;
      int  exp_cnt;
      for (int a = 0; a < DEPTH; a++) begin
         int s = ref_syn(mem[a]);
         if (s != 0) begin
            exp_q.push_back('{addr: a, data: ref_fix(mem[a])});
            nerr++;
            exp_last_addr = a;
            exp_last_syn  = s;
         end
      end
      exp_cnt = (nerr > CNT_MAX) ? CNT_MAX : nerr;
      rd_log.delete();
      wr_log.delete();

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      check({tag, ".busy_first"}, 32'(busy), 32'd1);
      check({tag, ".cnt_cleared"}, 32'(err_count), 32'd0);
      check({tag, ".addr_cleared"}, 32'(mem_if.mem_addr), 32'd0);
      while (done !== 1'b1 && cyc < 2000) begin
         if (poke_start) start = 1'($urandom_range(1, 0));
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({tag, ".done_seen"}, 32'(done), 32'd1);
      if (chk_time)
         check({tag, ".done_cycle"}, 32'(cyc), 32'(4 * DEPTH + nerr * (1 + wr_dly_min) + 1));
      check({tag, ".busy_in_done"}, 32'(busy), 32'd1);
      check({tag, ".err_count"}, 32'(err_count), 32'(exp_cnt));
      check({tag, ".n_writes"}, 32'(wr_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
         check({tag, ".wr_addr"}, 32'(wr_log[i].addr), 32'(exp_q[i].addr));
         check({tag, ".wr_data"}, 32'(wr_log[i].data), 32'(exp_q[i].data));
      end
      bad = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (i >= rd_log.size() || rd_log[i] != i) bad = i;
      check({tag, ".read_order_first_bad"}, 32'(bad), 32'hFFFF_FFFF);
      check({tag, ".n_reads"}, 32'(rd_log.size()), 32'(DEPTH));
`ifdef HAMMING_SCRUB_LOG_EN
      check({tag, ".last_err_addr"}, 32'(last_err_addr), 32'(exp_last_addr));
      check({tag, ".last_err_syn"}, 32'(last_err_syn), 32'(exp_last_syn));
`endif
      // start during DONE must not launch another sweep
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ".done_pulse_1cyc"}, 32'(done), 32'd0);
      check({tag, ".idle_after_done"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check({tag, ".still_idle"}, 32'(busy), 32'd0);
      check({tag, ".err_count_held"}, 32'(err_count), 32'(exp_cnt));
   endtask

   typedef struct {
      int         addr;
      logic [6:0] word;
      logic [6:0] fixed;
      bit         err;
   } vec_t;
   vec_t tbl[11];

   initial begin
      int cyc;
      tbl[0]  = '{addr: 0,  word: 7'b1010101, fixed: 7'b1010101, err: 1'b0};
      tbl[1]  = '{addr: 3,  word: 7'b1010100, fixed: 7'b1010101, err: 1'b1};
      tbl[2]  = '{addr: 15, word: 7'b1010111, fixed: 7'b1010101, err: 1'b1};
      tbl[3]  = '{addr: 7,  word: 7'b1010001, fixed: 7'b1010101, err: 1'b1};
      tbl[4]  = '{addr: 9,  word: 7'b1011101, fixed: 7'b1010101, err: 1'b1};
      tbl[5]  = '{addr: 2,  word: 7'b1000101, fixed: 7'b1010101, err: 1'b1};
      tbl[6]  = '{addr: 11, word: 7'b1110101, fixed: 7'b1010101, err: 1'b1};
      tbl[7]  = '{addr: 0,  word: 7'b0010101, fixed: 7'b1010101, err: 1'b1};
      tbl[8]  = '{addr: 6,  word: 7'b1000000, fixed: 7'b0000000, err: 1'b1};
      tbl[9]  = '{addr: 12, word: 7'b1010110, fixed: 7'b1010010, err: 1'b1};
      tbl[10] = '{addr: 4,  word: 7'b1111111, fixed: 7'b1111111, err: 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      fill_clean();
      repeat (2) @(negedge clk);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.rd_en", 32'(mem_if.mem_rd_en), 32'd0);
      check("rst.wr_en", 32'(mem_if.mem_wr_en), 32'd0);
      check("rst.err_count", 32'(err_count), 32'd0);
      check("rst.mem_addr", 32'(mem_if.mem_addr), 32'd0);
      check("rst.wr_data", 32'(mem_if.mem_wr_data), 32'd0);
`ifdef HAMMING_SCRUB_LOG_EN
      check("rst.last_err_addr", 32'(last_err_addr), 32'd0);
      check("rst.last_err_syn", 32'(last_err_syn), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Single-word table: each entry planted in an otherwise clean store.
      set_lat(1, 1, 0, 0, 1'b0);
      for (int i = 0; i < 11; i++) begin
         fill_clean();
         mem[tbl[i].addr] = tbl[i].word;
         run_sweep($sformatf("tbl%0d", i), 1'b1, 1'b0);
         check($sformatf("tbl%0d.mem_after", i), 32'(mem[tbl[i].addr]), 32'(tbl[i].fixed));
         check($sformatf("tbl%0d.wrote", i), 32'(wr_log.size()), 32'(tbl[i].err));
      end

      // Two errors: addr3 bit0, addr9 bit3.
      fill_clean();
      mem[3] = 7'b1010100;
      mem[9] = 7'b1011101;
      run_sweep("two_err", 1'b1, 1'b0);
      check("two_err.count", 32'(err_count), 32'd2);
`ifdef HAMMING_SCRUB_LOG_EN
      check("two_err.log_addr", 32'(last_err_addr), 32'd9);
      check("two_err.log_syn", 32'(last_err_syn), 32'd4);
`endif

      // Write back-pressure: ready low 5 cycles, accepted on the 6th.
      fill_clean();
      mem[5] = 7'b0010101;
      set_lat(1, 1, 5, 5, 1'b0);
      run_sweep("backpressure", 1'b1, 1'b0);
      check("backpressure.wr_cycles", 32'(last_wr_cycles), 32'd6);

      // Reset while stalled in WR at addr9, then a fresh sweep from addr0.
      fill_clean();
      mem[9] = 7'b1011101;
      set_lat(1, 1, 3, 3, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (!(mem_if.mem_wr_en === 1'b1 && mem_if.mem_addr == 4'd9) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("abort.reached_wr9", 32'(mem_if.mem_wr_en), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_last_addr = 0;
      exp_last_syn  = 0;
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.wr_en", 32'(mem_if.mem_wr_en), 32'd0);
      check("abort.err_count", 32'(err_count), 32'd0);
      check("abort.mem_addr", 32'(mem_if.mem_addr), 32'd0);
      check("abort.mem_unchanged", 32'(mem[9]), 32'(7'b1011101));
`ifdef HAMMING_SCRUB_LOG_EN
      check("abort.log_addr", 32'(last_err_addr), 32'd0);
`endif
      @(negedge clk);
      set_lat(1, 1, 0, 0, 1'b0);
      run_sweep("resume", 1'b1, 1'b0);

      // Counter saturation with start re-pulsed mid-sweep.
      fill_clean();
      mem[1]  = 7'b1010100;
      mem[4]  = 7'b1000101;
      mem[7]  = 7'b1110101;
      mem[10] = 7'b0010101;
      mem[13] = 7'b1010001;
      run_sweep("saturate", 1'b1, 1'b1);
      check("saturate.count", 32'(err_count), 32'(CNT_MAX));

      // Randomized sweeps with variable latency, back-pressure and bus noise.
      set_lat(1, 3, 0, 3, 1'b1);
      for (int n = 0; n < 6; n++) begin
         for (int a = 0; a < DEPTH; a++)
            mem[a] = ($urandom_range(1, 0) == 1) ? ref_fix(7'($urandom)) : 7'($urandom);
         run_sweep($sformatf("rand%0d", n), 1'b0, 1'b1);
         for (int a = 0; a < DEPTH; a++)
            check($sformatf("rand%0d.clean_after", n), 32'(ref_syn(mem[a])), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
